// File: rtl/mult4x4_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult4x4_share_ctrl
// Brief    : 4x4 unsigned multiplier built on one shared, registered 2x2 lookup
//            table, arbitrated round-robin between two requesters.
// Revision : 1.0
// ============================================================================
module mult4x4_share_ctrl #(
    parameter int LUT_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic [1:0] lut_a,
    output logic [1:0] lut_b,
    input  logic [3:0] lut_out,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_id,
    input  logic       rsp_ready
);

    localparam int PIPE_DEPTH = LUT_LAT + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] a_q, b_q;
    logic       id_q;
    logic       last_gnt_q;
    logic [7:0] acc_q;
    logic [1:0] step_q;
    logic [1:0] lut_a_q, lut_b_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;
    logic       rsp_id_q;

    // Each entry is {valid, step}; the last entry lines up with lut_out.
    logic [PIPE_DEPTH-1:0][2:0] tag_q;

    logic       w_idle;
    logic       w_issue;
    logic       w_gnt1;
    logic       w_accept;
    logic       w_ret_vld;
    logic [1:0] w_ret_step;
    logic       w_last_ret;
    logic [7:0] w_partial;

    assign w_idle     = (state_q == S_IDLE);
    assign w_issue    = (state_q == S_ISSUE);
    // last_gnt_q == 1 means requester 0 wins a tie.
    assign w_gnt1     = req1_valid & (~req0_valid | ~last_gnt_q);
    assign req0_ready = w_idle & req0_valid & ~w_gnt1;
    assign req1_ready = w_idle & w_gnt1;
    assign w_accept   = req0_ready | req1_ready;

    assign w_ret_vld  = tag_q[PIPE_DEPTH-1][2];
    assign w_ret_step = tag_q[PIPE_DEPTH-1][1:0];
    assign w_last_ret = w_ret_vld & (w_ret_step == 2'd3);

    assign lut_a     = lut_a_q;
    assign lut_b     = lut_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

    always_comb begin
        w_partial = {4'b0000, lut_out};
        case (w_ret_step)
            2'd0:       w_partial = {lut_out, 4'b0000};
            2'd1, 2'd2: w_partial = {2'b00, lut_out, 2'b00};
            default:    w_partial = {4'b0000, lut_out};
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept)                 state_d = S_ISSUE;
            S_ISSUE: if (step_q == 2'd3)           state_d = S_DRAIN;
            S_DRAIN: if (w_last_ret)               state_d = S_RESP;
            S_RESP:  if (rsp_valid_q && rsp_ready) state_d = S_IDLE;
            default:                               state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= {w_issue, step_q};
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            id_q        <= 1'b0;
            last_gnt_q  <= 1'b1;
            acc_q       <= 8'd0;
            step_q      <= 2'd0;
            lut_a_q     <= 2'd0;
            lut_b_q     <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (w_accept) begin
                a_q        <= w_gnt1 ? req1_a : req0_a;
                b_q        <= w_gnt1 ? req1_b : req0_b;
                id_q       <= w_gnt1;
                last_gnt_q <= w_gnt1;
                step_q     <= 2'd0;
            end else if (w_issue) begin
                step_q <= step_q + 2'd1;
            end

            // Step order hi*hi, hi*lo, lo*hi, lo*lo.
            if (w_issue) begin
                lut_a_q <= step_q[1] ? a_q[1:0] : a_q[3:2];
                lut_b_q <= step_q[0] ? b_q[1:0] : b_q[3:2];
            end else begin
                lut_a_q <= 2'd0;
                lut_b_q <= 2'd0;
            end

            if (w_accept) begin
                acc_q <= 8'd0;
            end else if (w_ret_vld) begin
                acc_q <= acc_q + w_partial;
            end

            if ((state_q == S_DRAIN) && w_last_ret) begin
                rsp_data_q  <= acc_q + w_partial;
                rsp_id_q    <= id_q;
                rsp_valid_q <= 1'b1;
            end else if ((state_q == S_RESP) && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
